counter1: RTL and testbench



---
 rtl/counter1.sv | 57 +++++
 tb/tb_counter1.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/counter1.sv
// Stepped repeating counter: walks MIN_VAL..MAX_VAL, holding each value REPEAT cycles.
// Optional count enable port compiled in with COUNTER1_ENABLE_EN.
module counter1 #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned MIN_VAL = 1,
    parameter int unsigned MAX_VAL = 7,
    parameter int unsigned REPEAT  = 3
) (
    input  logic             clk,
    input  logic             rst,
`ifdef COUNTER1_ENABLE_EN
    input  logic             en,
`endif
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam int unsigned       HOLD_W    = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT - 1);
    localparam logic [WIDTH-1:0]  MIN_C     = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0]  MAX_C     = WIDTH'(MAX_VAL);

    logic [HOLD_W-1:0] hold;
    logic              step;

    always_comb begin
`ifdef COUNTER1_ENABLE_EN
        step = en;
`else
        step = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= MIN_C;
            hold  <= '0;
            wrap  <= 1'b0;
        end else if (!step) begin
            // frozen edge: value and hold position kept, wrap pulse dropped
            wrap <= 1'b0;
        end else if (hold != HOLD_LAST) begin
            hold <= hold + HOLD_W'(1);
            wrap <= 1'b0;
        end else begin
            hold <= '0;
            if (count == MAX_C) begin
                count <= MIN_C;
                wrap  <= 1'b1;
            end else begin
                count <= count + WIDTH'(1);
                wrap  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_counter1.sv
// Scoreboard bench for counter1: default-parameter DUT plus a REPEAT=1, 2..5 variant,
// both checked against an index-based model of the stepped sequence.
module tb_counter1;

    typedef struct {
        int unsigned c;
        logic        w;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en_s;
    logic [2:0] count_main;
    logic       wrap_main;
    logic [2:0] count_swp;
    logic       wrap_swp;

    int unsigned checks;
    int unsigned errors;

    exp_t q_main[$];
    exp_t q_swp[$];

    int unsigned n_main;
    int unsigned n_swp;

    counter1 #(.WIDTH(3), .MIN_VAL(1), .MAX_VAL(7), .REPEAT(3)) dut_main (
        .clk(clk),
        .rst(rst),
`ifdef COUNTER1_ENABLE_EN
        .en(en_s),
`endif
        .count(count_main),
        .wrap(wrap_main)
    );

    counter1 #(.WIDTH(3), .MIN_VAL(2), .MAX_VAL(5), .REPEAT(1)) dut_swp (
        .clk(clk),
        .rst(rst),
`ifdef COUNTER1_ENABLE_EN
        .en(en_s),
`endif
        .count(count_swp),
        .wrap(wrap_swp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value shown after n enabled edges since reset release.
    function automatic int unsigned seq_val(input int unsigned n, input int unsigned mn,
                                            input int unsigned mx, input int unsigned r);
        return mn + (n / r) % (mx - mn + 1);
    endfunction

    function automatic logic seq_wrap(input int unsigned n, input int unsigned mn,
                                      input int unsigned mx, input int unsigned r);
        return (n != 0) && (n % (r * (mx - mn + 1)) == 0);
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive inputs for the next rising edge and record what each DUT must show after it.
    task automatic drive(input logic r, input logic e);
        exp_t x;
        logic adv;
        @(negedge clk);
        rst  = r;
        en_s = e;
`ifdef COUNTER1_ENABLE_EN
        adv = e;
`else
        adv = 1'b1;
`endif
        if (r) begin
            n_main = 0;
            n_swp  = 0;
        end else if (adv) begin
            n_main++;
            n_swp++;
        end
        x.c = seq_val(n_main, 1, 7, 3);
        x.w = !r && adv && seq_wrap(n_main, 1, 7, 3);
        q_main.push_back(x);
        x.c = seq_val(n_swp, 2, 5, 1);
        x.w = !r && adv && seq_wrap(n_swp, 2, 5, 1);
        q_swp.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q_main.size() > 0) begin
                x = q_main.pop_front();
                check("main_count", count_main, x.c);
                check("main_wrap", wrap_main, x.w);
            end
            if (q_swp.size() > 0) begin
                x = q_swp.pop_front();
                check("swp_count", count_swp, x.c);
                check("swp_wrap", wrap_swp, x.w);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned guard;
        checks = 0;
        errors = 0;
        n_main = 0;
        n_swp  = 0;
        rst    = 1'b1;
        en_s   = 1'b1;

        repeat (2) drive(1'b1, 1'b1);
        repeat (24) drive(1'b0, 1'b1);

        // long randomized run; en toggles only when the port exists
        for (int i = 0; i < 105; i++) begin
`ifdef COUNTER1_ENABLE_EN
            drive(1'b0, ($urandom_range(0, 3) != 0));
`else
            drive(1'b0, 1'b1);
`endif
        end

        // reset while count=5 is in its second hold cycle
        guard = 0;
        while (!(seq_val(n_main, 1, 7, 3) == 5 && n_main % 3 == 1) && guard < 50) begin
            drive(1'b0, 1'b1);
            guard++;
        end
        drive(1'b1, 1'b1);
        repeat (8) drive(1'b0, 1'b1);

`ifdef COUNTER1_ENABLE_EN
        // freeze count=3 in its second hold cycle
        guard = 0;
        while (!(seq_val(n_main, 1, 7, 3) == 3 && n_main % 3 == 1) && guard < 50) begin
            drive(1'b0, 1'b1);
            guard++;
        end
        repeat (4) drive(1'b0, 1'b0);
        repeat (6) drive(1'b0, 1'b1);
        // reset must win over a low enable
        drive(1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b1);
`endif

        // random tail with occasional resets
        for (int i = 0; i < 80; i++) begin
`ifdef COUNTER1_ENABLE_EN
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
`else
            drive(($urandom_range(0, 15) == 0), 1'b1);
`endif
        end

        repeat (2) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
